median_feeder: RTL and testbench
================================

MEDIAN_FEEDER -- requirements
Module: median_feeder

Interface
REQ-001 SHALL have parameter width, default 8: pixel and result bit width.
REQ-002 SHALL have parameter TIMEOUT, default 64: maximum WAIT cycles for median DSO; legal range is 1..255.
REQ-003 SHALL have port CLK, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port nRST, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port PI, input, width bits: upstream pixel.
REQ-006 SHALL have port PVALID, input, 1 bit: PI is valid.
REQ-007 SHALL have port PREADY, output, 1 bit: feeder accepts PI.
REQ-008 SHALL have port DI, output, width bits: pixel to the median filter.
REQ-009 SHALL have port DSI, output, 1 bit: pixel strobe to the median filter.
REQ-010 SHALL have port MDO, input, width bits: median filter result.
REQ-011 SHALL have port MDSO, input, 1 bit: median filter result valid (sticky until filter reset).
REQ-012 SHALL have port MNRST, output, 1 bit: active-low re-arm of the median filter.
REQ-013 SHALL have port RO, output, width bits: captured median.
REQ-014 SHALL have port RVALID, output, 1 bit: RO valid.
REQ-015 SHALL have port RREADY, input, 1 bit: downstream accepts RO.
REQ-016 SHALL have port ERR, output, 1 bit: sticky timeout flag.

Function
REQ-017 SHALL implement the FSM COLLECT -> SEND -> WAIT -> OUT -> COLLECT; reset state is COLLECT.
REQ-018 SHALL, in COLLECT, drive PREADY=1, store one pixel per cycle with PVALID&PREADY into a 9-entry buffer in arrival order, and enter SEND on the 9th accepted pixel.
REQ-019 SHALL, in SEND, drive DSI=1 for exactly 9 consecutive cycles with DI = buffer[0..8] in arrival order, then enter WAIT; PREADY=0 outside COLLECT.
REQ-020 SHALL, in WAIT, drive DSI=0 and DI=0, and on the first cycle with MDSO=1 register MDO into RO and enter OUT.
REQ-021 SHALL, in OUT, hold RVALID=1 and RO stable until RVALID&RREADY; on that cycle SHALL enter COLLECT and drive MNRST=0 for exactly the next cycle (registered output).
REQ-022 SHALL ignore MDSO outside WAIT.
REQ-023 SHALL accept a new pixel in the first COLLECT cycle after the OUT handshake; pixel-to-result latency is 9 SEND cycles + filter latency + 1 capture cycle.
REQ-024 SHALL keep the pixel counter (0..8) and send counter (0..8) 4 bits wide, cleared on each state entry; neither counter SHALL wrap within a state.

Reset
REQ-025 SHALL, while nRST=0, force state=COLLECT, counters=0, PREADY=0, DSI=0, DI=0, RO=0, RVALID=0, ERR=0, MNRST=0, and clear the buffer to 0.
REQ-026 SHALL, on the first clock after nRST deasserts, drive MNRST=1 and PREADY=1.
REQ-027 SHALL discard any partially collected or partially sent window when reset is asserted mid-operation.

Configuration
REQ-028 With MEDIAN_FEEDER_TIMEOUT_EN defined, SHALL count WAIT cycles; when the count reaches TIMEOUT without MDSO, SHALL set ERR=1 (sticky until reset), load RO=0, and enter OUT.
REQ-029 Without MEDIAN_FEEDER_TIMEOUT_EN, SHALL wait in WAIT indefinitely, SHALL tie ERR to 0, and SHALL contain no timeout counter.

Structure
REQ-030 SHALL take from shared package median_pkg the state enum (COLLECT, SEND, WAIT, OUT) and constant NPIX=9.
REQ-031 SHALL place the 9-entry buffer in sub-module median_sreg, which provides shift-in on accept and indexed read for SEND.

Verification
REQ-032 Bench SHALL cover: pixels 9,1,8,2,7,3,6,4,5 with the filter attached -> DI sequence identical over 9 DSI cycles; RO=5; RVALID=1.
REQ-033 Bench SHALL cover: PVALID toggled every other cycle -> exactly 9 accepted pixels; SEND starts the cycle after the 9th accept.
REQ-034 Bench SHALL cover: RREADY held 0 for 5 cycles in OUT -> RO and RVALID stable; MNRST pulses low for 1 cycle after the handshake.
REQ-035 Bench SHALL cover: MDSO tied 0 with TIMEOUT=16 and the macro defined -> ERR=1 and RO=0 after 16 WAIT cycles; with the macro undefined -> remains in WAIT.
REQ-036 Bench SHALL cover: nRST pulsed low during the 4th SEND cycle -> DSI=0 immediately; the next window of values 0..8 yields RO=4.
REQ-037 Bench SHALL cover: 3 back-to-back windows with all-0xFF, all-0x00, and 0x00..0x08 -> RO=0xFF, 0x00, 0x04.

Source files
------------

// File: rtl/median_pkg.sv
// Shared types and constants for the median filter feeder.
package median_pkg;

    localparam int NPIX = 9;
    localparam int CW   = 4;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SEND    = 2'd1,
        WAIT    = 2'd2,
        OUT     = 2'd3
    } state_t;

endpackage

// File: rtl/median_sreg.sv
// Nine-entry pixel window: shifts in at the tail so entry 0 is the oldest,
// indexed read-out drives the replay toward the filter.
module median_sreg
    import median_pkg::*;
#(
    parameter int width = 8
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             shift,
    input  logic [width-1:0] din,
    input  logic [CW-1:0]    idx,
    output logic [width-1:0] dout
);

    logic [NPIX-1:0][width-1:0] mem;

    // Shift toward index 0 on every accepted pixel; reset clears the window.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mem <= '0;
        end else if (shift) begin
            for (int i = 0; i < NPIX - 1; i++) mem[i] <= mem[i+1];
            mem[NPIX-1] <= din;
        end
    end

    // Out-of-range indices read as zero rather than X.
    always_comb begin
        dout = '0;
        if (idx < CW'(NPIX)) dout = mem[idx];
    end

endmodule

// File: rtl/median_feeder.sv
// Collects a 3x3 window of pixels, replays it into a median filter,
// captures the median and presents it downstream with a valid/ready handshake.
// Optional build macro MEDIAN_FEEDER_TIMEOUT_EN adds a bounded wait on the
// filter result with a sticky ERR flag.
module median_feeder
    import median_pkg::*;
#(
    parameter int width   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [width-1:0] PI,
    input  logic             PVALID,
    output logic             PREADY,
    output logic [width-1:0] DI,
    output logic             DSI,
    input  logic [width-1:0] MDO,
    input  logic             MDSO,
    output logic             MNRST,
    output logic [width-1:0] RO,
    output logic             RVALID,
    input  logic             RREADY,
    output logic             ERR
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("median_feeder: TIMEOUT must be within 1..255");
    end

    state_t           state, state_n;
    logic [CW-1:0]    pcnt, scnt;
    logic             pready_q, mnrst_q;
    logic [width-1:0] ro_q, buf_rd;
    logic             accept, tmo;

    assign accept = PVALID & pready_q;
    assign PREADY = pready_q;
    assign MNRST  = mnrst_q;
    assign RO     = ro_q;
    assign RVALID = (state == OUT);
    assign DSI    = (state == SEND);
    assign DI     = (state == SEND) ? buf_rd : '0;

    median_sreg #(.width(width)) u_sreg (
        .CLK  (CLK),
        .nRST (nRST),
        .shift(accept),
        .din  (PI),
        .idx  (scnt),
        .dout (buf_rd)
    );

`ifdef MEDIAN_FEEDER_TIMEOUT_EN
    logic [7:0] tcnt;
    logic       err_q;

    assign tmo = (tcnt == 8'(TIMEOUT - 1));
    assign ERR = err_q;

    // Count WAIT cycles without a filter result; flag and give up at the limit.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            tcnt  <= '0;
            err_q <= 1'b0;
        end else if (state == WAIT && !MDSO) begin
            tcnt <= tmo ? 8'd0 : tcnt + 8'd1;
            if (tmo) err_q <= 1'b1;
        end else begin
            tcnt <= '0;
        end
    end
`else
    assign tmo = 1'b0;
    assign ERR = 1'b0;
`endif

    // State, counters and registered handshake outputs.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= COLLECT;
            pcnt     <= '0;
            scnt     <= '0;
            pready_q <= 1'b0;
            mnrst_q  <= 1'b0;
            ro_q     <= '0;
        end else begin
            state    <= state_n;
            // Ready tracks the state we are entering, so it rises one clock
            // after reset and drops as soon as the 9th pixel lands.
            pready_q <= (state_n == COLLECT);
            // Re-arm pulse: filter held in reset for one cycle after hand-off.
            mnrst_q  <= !(state == OUT && RREADY);
            case (state)
                COLLECT: if (accept) pcnt <= (pcnt == CW'(NPIX - 1)) ? '0 : pcnt + 1'b1;
                SEND:    scnt <= (scnt == CW'(NPIX - 1)) ? '0 : scnt + 1'b1;
                WAIT: begin
                    if (MDSO)     ro_q <= MDO;
                    else if (tmo) ro_q <= '0;
                end
                default: ;
            endcase
        end
    end

    // Next-state: one window in, nine strobes out, wait for the median, hand off.
    always_comb begin
        state_n = state;
        case (state)
            COLLECT: if (accept && pcnt == CW'(NPIX - 1)) state_n = SEND;
            SEND:    if (scnt == CW'(NPIX - 1)) state_n = WAIT;
            WAIT:    if (MDSO || tmo) state_n = OUT;
            OUT:     if (RREADY) state_n = COLLECT;
            default: state_n = COLLECT;
        endcase
    end

endmodule

// File: tb/tb_median_feeder.sv
// Bench for median_feeder with a behavioural median filter attached.
module tb_median_feeder;

    localparam int W   = 8;
    localparam int TMO = 16;

    logic         CLK = 1'b0;
    logic         nRST = 1'b1;
    logic [W-1:0] PI = '0;
    logic         PVALID = 1'b0;
    logic         PREADY;
    logic [W-1:0] DI;
    logic         DSI;
    logic [W-1:0] MDO;
    logic         MDSO;
    logic         MNRST;
    logic [W-1:0] RO;
    logic         RVALID;
    logic         RREADY = 1'b0;
    logic         ERR;

    int tests = 0;
    int fails = 0;

    median_feeder #(.width(W), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .nRST(nRST), .PI(PI), .PVALID(PVALID), .PREADY(PREADY),
        .DI(DI), .DSI(DSI), .MDO(MDO), .MDSO(MDSO), .MNRST(MNRST),
        .RO(RO), .RVALID(RVALID), .RREADY(RREADY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    // Reference median: sort a copy, take the middle.
    function automatic logic [7:0] median9(input logic [7:0] a[9]);
        logic [7:0] s[9];
        logic [7:0] t;
        for (int i = 0; i < 9; i++) s[i] = a[i];
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (s[j] > s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
        return s[4];
    endfunction

    // Behavioural median filter: 9 strobes, then sticky result 3 cycles later.
    logic [7:0] fq[$];
    logic [7:0] fa[9];
    int         lat = 0;
    logic       mdso_r = 1'b0;
    logic [7:0] mdo_r = '0;
    bit         filt_en = 1'b1;
    assign MDSO = mdso_r & filt_en;
    assign MDO  = mdo_r;

    always @(posedge CLK or negedge MNRST) begin
        if (!MNRST) begin
            fq.delete();
            lat = 0;
            mdso_r <= 1'b0;
            mdo_r  <= '0;
        end else begin
            if (DSI && fq.size() < 9) fq.push_back(DI);
            if (fq.size() == 9 && !mdso_r) begin
                if (lat == 3) begin
                    for (int i = 0; i < 9; i++) fa[i] = fq[i];
                    mdso_r <= 1'b1;
                    mdo_r  <= median9(fa);
                end else lat++;
            end
        end
    end

    // Observation log: DI on each strobe, accept count, SEND start cycle.
    logic [7:0] di_log[$];
    int cyc = 0, acc_cnt = 0, acc9_cyc = -1, dsi_start = -1;
    logic dsi_prev = 1'b0;
    always @(posedge CLK) begin
        cyc++;
        if (DSI) di_log.push_back(DI);
        if (PVALID && PREADY) begin
            acc_cnt++;
            if (acc_cnt == 9) acc9_cyc = cyc;
        end
        if (DSI && !dsi_prev) dsi_start = cyc;
        dsi_prev = DSI;
    end

    // Present pixels p[start..8]; toggle=1 drops PVALID every other cycle.
    task automatic feed(input logic [7:0] p[9], input bit toggle, input int start);
        int k = start;
        int n = 0;
        while (k < 9 && n < 300) begin
            @(negedge CLK);
            n++;
            if (toggle && (n % 2 == 0)) PVALID = 1'b0;
            else begin PVALID = 1'b1; PI = p[k]; end
            if (PVALID && PREADY) k++;
        end
        @(negedge CLK);
        PVALID = 1'b0;
    endtask

    task automatic wait_rvalid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (RVALID) begin ok = 1'b1; break; end
            @(negedge CLK);
        end
    endtask

    task automatic handshake();
        @(negedge CLK); RREADY = 1'b1;
        @(negedge CLK); RREADY = 1'b0;
    endtask

    task automatic rand_win(output logic [7:0] p[9]);
        for (int i = 0; i < 9; i++) p[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic test_reset();
        #1 nRST = 1'b0;
        @(negedge CLK);
        tests++; if (PREADY !== 1'b0) begin fails++; $display("FAIL reset_pready got=%b exp=0", PREADY); end
        tests++; if (DSI !== 1'b0 || DI !== 8'h00) begin fails++; $display("FAIL reset_dsi_di got=%b/%h exp=0/00", DSI, DI); end
        tests++; if (RO !== 8'h00 || RVALID !== 1'b0) begin fails++; $display("FAIL reset_ro got=%h/%b exp=00/0", RO, RVALID); end
        tests++; if (ERR !== 1'b0 || MNRST !== 1'b0) begin fails++; $display("FAIL reset_err_mnrst got=%b/%b exp=0/0", ERR, MNRST); end
        nRST = 1'b1;
        @(negedge CLK);
        tests++; if (MNRST !== 1'b1 || PREADY !== 1'b1) begin fails++; $display("FAIL reset_release got mnrst=%b pready=%b exp=1/1", MNRST, PREADY); end
    endtask

    task automatic test_basic();
        logic [7:0] p[9];
        bit ok;
        p = '{8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4, 8'd5};
        di_log.delete();
        feed(p, 1'b0, 0);
        wait_rvalid(ok);
        tests++; if (!ok) begin fails++; $display("FAIL basic_timeout got=no_rvalid exp=rvalid"); end
        tests++; if (di_log.size() != 9) begin fails++; $display("FAIL basic_dsi_count got=%0d exp=9", di_log.size()); end
        for (int i = 0; i < 9 && i < di_log.size(); i++) begin
            tests++; if (di_log[i] !== p[i]) begin fails++; $display("FAIL basic_di[%0d] got=%h exp=%h", i, di_log[i], p[i]); end
        end
        tests++; if (RO !== 8'd5 || RVALID !== 1'b1) begin fails++; $display("FAIL basic_ro got=%h/%b exp=05/1", RO, RVALID); end
        handshake();
    endtask

    task automatic test_toggle();
        logic [7:0] p[9];
        bit ok;
        rand_win(p);
        acc_cnt = 0; acc9_cyc = -1; dsi_start = -1;
        feed(p, 1'b1, 0);
        for (int i = 0; i < 10; i++) begin @(negedge CLK); PVALID = ~PVALID; PI = 8'($urandom); end
        PVALID = 1'b0;
        tests++; if (acc_cnt != 9) begin fails++; $display("FAIL toggle_accepts got=%0d exp=9", acc_cnt); end
        tests++; if (dsi_start != acc9_cyc + 1) begin fails++; $display("FAIL toggle_send_start got=%0d exp=%0d", dsi_start, acc9_cyc + 1); end
        wait_rvalid(ok);
        tests++; if (!ok || RO !== median9(p)) begin fails++; $display("FAIL toggle_ro got=%h exp=%h", RO, median9(p)); end
        handshake();
    endtask

    task automatic test_hold();
        logic [7:0] p[9], p2[9];
        logic [7:0] exp;
        bit ok;
        rand_win(p); rand_win(p2);
        exp = median9(p);
        feed(p, 1'b0, 0);
        wait_rvalid(ok);
        tests++; if (!ok) begin fails++; $display("FAIL hold_timeout got=no_rvalid exp=rvalid"); end
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            tests++; if (RVALID !== 1'b1 || RO !== exp) begin fails++; $display("FAIL hold_stable[%0d] got=%h/%b exp=%h/1", i, RO, RVALID, exp); end
        end
        RREADY = 1'b1;
        @(negedge CLK);
        RREADY = 1'b0;
        tests++; if (MNRST !== 1'b0 || RVALID !== 1'b0 || PREADY !== 1'b1) begin fails++; $display("FAIL hold_after_hs got mnrst=%b rvalid=%b pready=%b exp=0/0/1", MNRST, RVALID, PREADY); end
        acc_cnt = 0;
        PVALID = 1'b1; PI = p2[0];
        @(negedge CLK);
        PVALID = 1'b0;
        tests++; if (MNRST !== 1'b1) begin fails++; $display("FAIL hold_mnrst_pulse got=%b exp=1", MNRST); end
        tests++; if (acc_cnt != 1) begin fails++; $display("FAIL hold_first_accept got=%0d exp=1", acc_cnt); end
        feed(p2, 1'b0, 1);
        wait_rvalid(ok);
        tests++; if (!ok || RO !== median9(p2)) begin fails++; $display("FAIL hold_next_ro got=%h exp=%h", RO, median9(p2)); end
        handshake();
    endtask

    task automatic test_midreset();
        logic [7:0] p[9], q[9];
        bit ok;
        int n = 0;
        rand_win(p);
        for (int i = 0; i < 9; i++) q[i] = 8'(i);
        feed(p, 1'b0, 0);
        while (!DSI && n < 50) begin @(negedge CLK); n++; end
        tests++; if (!DSI) begin fails++; $display("FAIL midrst_no_send got=%b exp=1", DSI); end
        repeat (3) @(negedge CLK);
        nRST = 1'b0;
        #1;
        tests++; if (DSI !== 1'b0 || DI !== 8'h00 || PREADY !== 1'b0) begin fails++; $display("FAIL midrst_immediate got dsi=%b di=%h pready=%b exp=0/00/0", DSI, DI, PREADY); end
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        di_log.delete();
        feed(q, 1'b0, 0);
        wait_rvalid(ok);
        tests++; if (!ok || RO !== 8'd4) begin fails++; $display("FAIL midrst_ro got=%h exp=04", RO); end
        tests++; if (di_log.size() != 9) begin fails++; $display("FAIL midrst_dsi_count got=%0d exp=9", di_log.size()); end
        handshake();
    endtask

    task automatic test_back_to_back();
        logic [7:0] w[3][9];
        logic [7:0] exp[3];
        logic [7:0] p[9];
        bit ok;
        for (int i = 0; i < 9; i++) begin w[0][i] = 8'hFF; w[1][i] = 8'h00; w[2][i] = 8'(i); end
        exp[0] = 8'hFF; exp[1] = 8'h00; exp[2] = 8'h04;
        RREADY = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 9; i++) p[i] = w[k][i];
            feed(p, 1'b0, 0);
            wait_rvalid(ok);
            tests++; if (!ok || RO !== exp[k]) begin fails++; $display("FAIL b2b_ro[%0d] got=%h exp=%h", k, RO, exp[k]); end
        end
        @(negedge CLK);
        RREADY = 1'b0;
    endtask

    task automatic test_timeout();
        logic [7:0] p[9];
        bit ok;
        int n = 0;
        int wcnt = 0;
        rand_win(p);
        filt_en = 1'b0;
        feed(p, 1'b0, 0);
        while (!DSI && n < 50) begin @(negedge CLK); n++; end
        while (DSI && n < 100) begin @(negedge CLK); n++; end
        while (!RVALID && wcnt < 40) begin wcnt++; @(negedge CLK); end
`ifdef MEDIAN_FEEDER_TIMEOUT_EN
        tests++; if (wcnt != TMO) begin fails++; $display("FAIL tmo_wait_cycles got=%0d exp=%0d", wcnt, TMO); end
        tests++; if (ERR !== 1'b1 || RO !== 8'h00 || RVALID !== 1'b1) begin fails++; $display("FAIL tmo_flag got err=%b ro=%h rvalid=%b exp=1/00/1", ERR, RO, RVALID); end
        handshake();
        tests++; if (ERR !== 1'b1) begin fails++; $display("FAIL tmo_sticky got=%b exp=1", ERR); end
        filt_en = 1'b1;
`else
        tests++; if (RVALID !== 1'b0 || ERR !== 1'b0) begin fails++; $display("FAIL tmo_stays_wait got rvalid=%b err=%b exp=0/0", RVALID, ERR); end
        filt_en = 1'b1;
        wait_rvalid(ok);
        tests++; if (!ok || RO !== median9(p)) begin fails++; $display("FAIL tmo_late_result got=%h exp=%h", RO, median9(p)); end
        handshake();
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_toggle();
        test_hold();
        test_midreset();
        test_back_to_back();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
